// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 access codes, data-bus views
// and the size/sign decode helpers used by the top and the lane-alignment block.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } lsu_state_e;

    // Encoded as {is_store, funct3} so loads and stores stay distinct
    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } mem_size_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    typedef union packed {
        logic [31:0]      word;
        logic [1:0][15:0] half;
        logic [3:0][7:0]  lane;
    } dataBus_u;

    // Undefined codes fall through to word size
    function automatic acc_size_e access_size(input logic [2:0] funct3);
        acc_size_e size;
        case (funct3)
            3'b000, 3'b100: size = SZ_BYTE;
            3'b001, 3'b101: size = SZ_HALF;
            default:        size = SZ_WORD;
        endcase
        return size;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store lane replication, byte enables
// and load shift with sign/zero extension. Purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    acc_size_e  size_s;
    logic       sext_s;
    logic [1:0] offset_s;
    dataBus_u   wr_s;
    dataBus_u   rd_s;

    // Offset honours only the address bits meaningful for the access size,
    // so misaligned halfwords/words are forced onto their natural boundary.
    always_comb begin
        size_s    = access_size(op[2:0]);
        sext_s    = is_signed_load(op[2:0]);
        wr_s.word = wdata;
        offset_s  = 2'b00;
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        case (size_s)
            SZ_BYTE: begin
                offset_s  = addr_lo;
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wr_s.lane[0]}};
            end
            SZ_HALF: begin
                offset_s  = {addr_lo[1], 1'b0};
                byte_en   = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wr_s.half[0]}};
            end
            default: begin
                offset_s  = 2'b00;
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
        rd_s.word = rdata >> {offset_s, 3'b000};
        case (size_s)
            SZ_BYTE: load_data = {{24{sext_s & rd_s.lane[0][7]}}, rd_s.lane[0]};
            SZ_HALF: load_data = {{16{sext_s & rd_s.half[0][15]}}, rd_s.half[0]};
            default: load_data = rd_s.word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, bounded wait for mem_ready, bus-error on timeout.
// Optional macro LSU_MISALIGN_EXC_EN flags misaligned halfword/word accesses instead of forcing alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        ex_rd_en,
    input  logic        ex_wr_en,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_bus_err,
    output logic        lsu_misalign,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int CNT_W = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    lsu_state_e       state_r;
    lsu_state_e       state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_s;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [31:0]      rdata_r;
    logic [3:0]       op_r;
    logic             misalign_r;
    logic             req_s;
    logic             busy_s;
    logic [3:0]       req_op_s;
    logic             misalign_req_s;
    logic [3:0]       byte_en_s;
    logic [31:0]      wdata_rep_s;
    logic [31:0]      load_data_s;

    assign req_s    = ex_rd_en | ex_wr_en;
    // A store request overrides a simultaneous load
    assign req_op_s = {ex_wr_en, ex_funct3};
    assign busy_s   = (state_r == ACCESS) || (state_r == WAIT);

`ifdef LSU_MISALIGN_EXC_EN
    // Detect halfword/word requests that cross their natural boundary
    always_comb begin
        case (access_size(ex_funct3))
            SZ_HALF: misalign_req_s = ex_addr[0];
            SZ_WORD: misalign_req_s = |ex_addr[1:0];
            default: misalign_req_s = 1'b0;
        endcase
    end
`else
    assign misalign_req_s = 1'b0;
`endif

    lsu_align u_align (
        .op        (op_r),
        .addr_lo   (addr_r[1:0]),
        .wdata     (wdata_r),
        .rdata     (mem_rdata),
        .byte_en   (byte_en_s),
        .wdata_rep (wdata_rep_s),
        .load_data (load_data_s)
    );

    // State, wait counter and request latches; everything holds while clk_en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            addr_r     <= 32'd0;
            wdata_r    <= 32'd0;
            rdata_r    <= 32'd0;
            op_r       <= 4'd0;
            misalign_r <= 1'b0;
        end else if (clk_en) begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if ((state_r == IDLE) && req_s) begin
                addr_r     <= ex_addr;
                wdata_r    <= ex_wdata;
                op_r       <= req_op_s;
                misalign_r <= misalign_req_s;
                rdata_r    <= 32'd0;
            end else if (busy_s && mem_ready && !op_r[3]) begin
                rdata_r    <= load_data_s;
            end
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_s    = misalign_req_s ? DONE : ACCESS;
                    wait_cnt_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    state_s = DONE;
                end else begin
                    state_s    = WAIT;
                    wait_cnt_s = CNT_W'(1);
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_s = DONE;
                end else if (wait_cnt_r == CNT_MAX) begin
                    state_s = ERR;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output decode; bus fields are zero unless an access is on the bus
    always_comb begin
        lsu_stall    = 1'b0;
        lsu_done     = 1'b0;
        lsu_bus_err  = 1'b0;
        lsu_misalign = 1'b0;
        lsu_rdata    = 32'd0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        mem_byte_en  = 4'd0;
        case (state_r)
            IDLE: lsu_stall = clk_en & req_s & ~rst;
            ACCESS, WAIT: begin
                lsu_stall   = 1'b1;
                mem_rd_en   = ~op_r[3];
                mem_wr_en   = op_r[3];
                mem_addr    = {addr_r[31:2], 2'b00};
                mem_wdata   = wdata_rep_s;
                mem_byte_en = byte_en_s;
            end
            DONE: begin
                lsu_done     = 1'b1;
                lsu_misalign = misalign_r;
                lsu_rdata    = rdata_r;
            end
            ERR: begin
                lsu_done    = 1'b1;
                lsu_bus_err = 1'b1;
            end
            default: lsu_stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic reference model.
// Honours LSU_MISALIGN_EXC_EN the same way as the design build.
module tb_load_store_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst, clk_en, ex_rd_en, ex_wr_en, mem_ready;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata, mem_rdata;
    logic        lsu_stall, lsu_done, lsu_bus_err, lsu_misalign, mem_rd_en, mem_wr_en;
    logic [31:0] lsu_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_byte_en;

    int n_cmp = 0;
    int n_err = 0;

    load_store_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .ex_rd_en(ex_rd_en), .ex_wr_en(ex_wr_en), .ex_funct3(ex_funct3),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done),
        .lsu_bus_err(lsu_bus_err), .lsu_misalign(lsu_misalign),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: access width in bytes from funct3
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic int lane_offset(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
        return (int'(a[1:0]) % size_bytes(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_byte_en(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be = 4'd0;
        int n   = size_bytes(f3);
        int off = lane_offset(f3, a);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = 32'd0;
        int n = size_bytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = size_bytes(f3);
        logic [31:0] v = rd >> (8 * lane_offset(f3, a));
        logic [31:0] mask;
        if (n == 4) return v;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check_value({tag, "_stall"}, lsu_stall, 32'd0);
        check_value({tag, "_rdata"}, lsu_rdata, 32'd0);
        check_value({tag, "_done"}, lsu_done, 32'd0);
        check_value({tag, "_buserr"}, lsu_bus_err, 32'd0);
        check_value({tag, "_misal"}, lsu_misalign, 32'd0);
        check_value({tag, "_maddr"}, mem_addr, 32'd0);
        check_value({tag, "_mwdata"}, mem_wdata, 32'd0);
        check_value({tag, "_mbe"}, mem_byte_en, 32'd0);
        check_value({tag, "_rden"}, mem_rd_en, 32'd0);
        check_value({tag, "_wren"}, mem_wr_en, 32'd0);
    endtask

    // One full transaction; called at a negedge with the DUT in IDLE, returns at a negedge in IDLE.
    // latency = cycles mem_ready stays low; beyond MAX_WAIT the access must time out.
    task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd, input int latency,
                             input bit freeze, input bit both);
        bit timeout = (latency > MAX_WAIT);
        ex_rd_en  = both ? 1'b1 : ~st;
        ex_wr_en  = st;
        ex_funct3 = f3;
        ex_addr   = a;
        ex_wdata  = wd;
        mem_ready = 1'b0;
        #1;
        check_value("stall_req", lsu_stall, 32'd1);
        @(negedge clk);
        ex_rd_en = 1'b0;
        ex_wr_en = 1'b0;
        if (is_misaligned(f3, a)) begin
            check_value("mis_done", lsu_done, 32'd1);
            check_value("mis_flag", lsu_misalign, 32'd1);
            check_value("mis_rdata", lsu_rdata, 32'd0);
            check_value("mis_rden", mem_rd_en, 32'd0);
            check_value("mis_wren", mem_wr_en, 32'd0);
            check_value("mis_stall", lsu_stall, 32'd0);
        end else begin
            check_value("acc_addr", mem_addr, {a[31:2], 2'b00});
            check_value("acc_be", mem_byte_en, exp_byte_en(f3, a));
            if (st) check_value("acc_wdata", mem_wdata, exp_wdata(f3, wd));
            if (freeze) begin
                clk_en    = 1'b0;
                mem_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_value("frz_done", lsu_done, 32'd0);
                    check_value("frz_en", {mem_wr_en, mem_rd_en}, st ? 32'd2 : 32'd1);
                end
                clk_en = 1'b1;
            end
            for (int k = 0; k <= MAX_WAIT; k++) begin
                check_value("bus_stall", lsu_stall, 32'd1);
                check_value("bus_done", lsu_done, 32'd0);
                check_value("bus_en", {mem_wr_en, mem_rd_en}, st ? 32'd2 : 32'd1);
                mem_ready = (k == latency);
                mem_rdata = (k == latency) ? rd : $urandom;
                @(negedge clk);
                if (k == latency) break;
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            #1;
            check_value("end_done", lsu_done, 32'd1);
            check_value("end_stall", lsu_stall, 32'd0);
            check_value("end_buserr", lsu_bus_err, timeout ? 32'd1 : 32'd0);
            check_value("end_misal", lsu_misalign, 32'd0);
            check_value("end_en", {mem_wr_en, mem_rd_en}, 32'd0);
            check_value("end_rdata", lsu_rdata, (timeout || st) ? 32'd0 : exp_load(f3, a, rd));
        end
        @(negedge clk);
        check_value("idle_done", lsu_done, 32'd0);
        check_value("idle_buserr", lsu_bus_err, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clk_en = 1'b1; ex_rd_en = 1'b0; ex_wr_en = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
        mem_rdata = 32'd0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst0");
        rst = 1'b0;

        // Directed cases, the first issued right after reset release
        do_access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_1234, 0, 1'b0, 1'b0);
        do_access(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 32'd0, 0, 1'b0, 1'b0);
        do_access(1'b0, 3'b010, 32'h100, 32'd0, 32'h1234_5678, 99, 1'b0, 1'b0);
        do_access(1'b0, 3'b010, 32'h104, 32'd0, 32'hCAFE_F00D, MAX_WAIT, 1'b0, 1'b0);
        do_access(1'b0, 3'b010, 32'h6, 32'd0, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        do_access(1'b1, 3'b010, 32'h48, 32'h1357_9BDF, 32'd0, 2, 1'b0, 1'b1);
        do_access(1'b0, 3'b110, 32'h8, 32'd0, 32'h8765_4321, 0, 1'b0, 1'b0);
        do_access(1'b0, 3'b100, 32'h9, 32'd0, 32'h0000_F200, 1, 1'b1, 1'b0);

        // Request while clk_en low is not accepted
        clk_en = 1'b0; ex_rd_en = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h10;
        #1;
        check_value("noen_stall", lsu_stall, 32'd0);
        @(negedge clk);
        check_value("noen_rden", mem_rd_en, 32'd0);
        ex_rd_en = 1'b0; clk_en = 1'b1;
        @(negedge clk);

        // Reset while waiting on the bus
        ex_rd_en = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h40;
        @(negedge clk);
        ex_rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_value("prerst_rden", mem_rd_en, 32'd1);
        rst = 1'b1; ex_rd_en = 1'b1;
        #1;
        check_all_zero("rstw");
        @(negedge clk);
        check_all_zero("rstw2");
        rst = 1'b0; ex_rd_en = 1'b0;
        do_access(1'b0, 3'b101, 32'h0, 32'd0, 32'h0000_F00F, 0, 1'b0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            bit          st  = 1'($urandom_range(0, 1));
            logic [2:0]  f3  = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            int          r   = $urandom_range(0, 11);
            int          lat = (r == 11) ? 40 : (r % 5);
            do_access(st, f3, $urandom, $urandom, $urandom, lat, ($urandom_range(0, 9) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
